// File: rtl/mc_cr_pkg.sv
// Shared types and constants for the chroma residual sequencer.
package mc_cr_pkg;

   // Sequencer state encoding. Values are fixed for compatibility with existing logic.
   typedef logic [2:0] mc_cr_state_e;
   localparam mc_cr_state_e ST_IDLE  = 3'd0;
   localparam mc_cr_state_e ST_FETCH = 3'd1;
   localparam mc_cr_state_e ST_ISSUE = 3'd2;
   localparam mc_cr_state_e ST_DRAIN = 3'd3;
   localparam mc_cr_state_e ST_FLUSH = 3'd4;
   localparam mc_cr_state_e ST_DONE  = 3'd5;

   typedef enum logic {
      CB = 1'b0,
      CR = 1'b1
   } chroma_comp_e;

   localparam int unsigned BEATS_PER_BLK = 32;
   localparam int unsigned IDX_W         = 5;

   typedef struct packed {
      chroma_comp_e     comp;
      logic [IDX_W-1:0] idx;
      logic             last;
   } beat_tag_t;

   localparam int unsigned TAG_W = $bits(beat_tag_t);

endpackage

// File: rtl/mc_cr_skid.sv
// Two-entry valid/ready FIFO used to decouple engine beats from the downstream consumer.
module mc_cr_skid #(
   parameter int unsigned WIDTH = 23
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             full,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign pop  = out_valid && out_ready;
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign push = in_valid && (!full || pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign full      = count[1];
   assign out_valid = |count;
   assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/mc_cr_ctrl.sv
// Sequences the mc_cr residual engine over Cb then Cr for each macroblock and
// forwards the tagged residual beats downstream through a skid buffer.
module mc_cr_ctrl
   import mc_cr_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned MB_SIZE     = 8,
   parameter int unsigned NUM_COMP    = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     mb_start,
   input  logic                     abort,
   output logic                     mb_busy,
   output logic                     mb_done,
   output logic                     fetch_req,
   output logic                     fetch_comp,
   input  logic                     fetch_done,
   output logic                     eng_src_valid,
   input  logic                     eng_src_ready,
   input  logic                     eng_dst_valid,
   output logic                     eng_dst_ready,
   input  logic [2*PIXEL_WIDTH-1:0] eng_res,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [2*PIXEL_WIDTH-1:0] res_data,
   output logic                     res_comp,
   output logic [4:0]               res_idx,
   output logic                     res_last
);

   localparam int unsigned      BEATS     = MB_SIZE * MB_SIZE / 2;
   localparam int unsigned      DATA_W    = 2 * PIXEL_WIDTH;
   localparam int unsigned      WORD_W    = TAG_W + DATA_W;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic             LAST_COMP = 1'(NUM_COMP - 1);

   mc_cr_state_e     state;
   mc_cr_state_e     state_nxt;
   logic             comp;
   logic [IDX_W-1:0] count;
   logic             beat_acc;
   logic             blk_end;
   logic             skid_full;
   logic             skid_valid;
   logic [WORD_W-1:0] push_word;
   logic [WORD_W-1:0] out_word;
   beat_tag_t        push_tag;
   beat_tag_t        out_tag;

   assign beat_acc = eng_dst_valid && eng_dst_ready;
   assign blk_end  = beat_acc && (count == LAST_IDX);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (mb_start) state_nxt = ST_FETCH;
         ST_FETCH: if (fetch_done) state_nxt = ST_ISSUE;
         ST_ISSUE: if (eng_src_ready) state_nxt = ST_DRAIN;
         ST_DRAIN: if (blk_end) state_nxt = (comp == LAST_COMP) ? ST_FLUSH : ST_FETCH;
         ST_FLUSH: if (!skid_valid) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         comp  <= CB;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (abort || state == ST_IDLE || state == ST_DONE) begin
            comp  <= CB;
            count <= '0;
         end else if (state == ST_ISSUE) begin
            count <= '0;
         end else if (state == ST_DRAIN && beat_acc) begin
            count <= count + IDX_ONE;
            if (blk_end && comp != LAST_COMP) begin
               comp <= comp + 1'b1;
            end
         end
      end
   end

   assign push_tag = '{comp: chroma_comp_e'(comp),
                       idx:  count,
                       last: (comp == LAST_COMP) && (count == LAST_IDX)};
   assign push_word = {push_tag, eng_res};

   mc_cr_skid #(
      .WIDTH(WORD_W)
   ) u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (abort),
      .in_valid (beat_acc),
      .in_data  (push_word),
      .full     (skid_full),
      .out_valid(skid_valid),
      .out_ready(res_ready),
      .out_data (out_word)
   );

   assign out_tag = out_word[DATA_W +: TAG_W];

   assign mb_busy       = (state != ST_IDLE);
   assign mb_done       = (state == ST_DONE);
   assign fetch_req     = (state == ST_FETCH);
   assign fetch_comp    = (state == ST_FETCH) && comp;
   assign eng_src_valid = (state == ST_ISSUE);
   assign eng_dst_ready = (state == ST_DRAIN) && !skid_full;
   assign res_valid     = skid_valid;
   assign res_data      = out_word[DATA_W-1:0];
   assign res_comp      = out_tag.comp;
   assign res_idx       = out_tag.idx;
   assign res_last      = out_tag.last;

endmodule
